// File: rtl/jac1_pkg.sv
// jac1_pkg: shared definitions for the JAC1-8 accumulator processor.
// Holds the opcode encodings, the instruction word layout and its field
// positions. Imported by jac1_alu and jac1_cpu_top.
// Build option: JAC1_HALT_EN (see jac1_cpu_top) changes how OP_HALT decodes.
package jac1_pkg;

  localparam int INSTR_W = 12;
  localparam int OPC_MSB = 11;
  localparam int OPC_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP  = 4'h0;
  localparam opcode_t OP_LDI  = 4'h1;
  localparam opcode_t OP_ADDI = 4'h2;
  localparam opcode_t OP_SUBI = 4'h3;
  localparam opcode_t OP_ANDI = 4'h4;
  localparam opcode_t OP_ORI  = 4'h5;
  localparam opcode_t OP_XORI = 4'h6;
  localparam opcode_t OP_NOT  = 4'h7;
  localparam opcode_t OP_SHL  = 4'h8;
  localparam opcode_t OP_SHR  = 4'h9;
  localparam opcode_t OP_JMP  = 4'hA;
  localparam opcode_t OP_JZ   = 4'hB;
  localparam opcode_t OP_JC   = 4'hC;
  localparam opcode_t OP_JNZ  = 4'hD;
  localparam opcode_t OP_HALT = 4'hE;

  // Field order matches the bit layout: opcode in [11:8], imm in [7:0].
  typedef struct packed {
    opcode_t    opcode;
    logic [7:0] imm;
  } instr_t;

  function automatic instr_t mk_instr(input opcode_t op, input logic [7:0] imm);
    instr_t w;
    w.opcode = op;
    w.imm    = imm;
    return w;
  endfunction

endpackage

// File: rtl/jac1_alu.sv
// jac1_alu: combinational ALU for the JAC1-8 processor.
// Ports:
//   acc_i      current accumulator
//   imm_i      instruction immediate
//   opcode_i   instruction opcode
//   carry_i    current C flag (passed through where C is unchanged)
//   result_o   new accumulator value
//   carry_o    new C flag
//   zero_o     new Z flag (result == 0)
//   we_o       1 when the opcode writes acc and flags
module jac1_alu
  import jac1_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic [DataWidth-1:0] acc_i,
  input  logic [DataWidth-1:0] imm_i,
  input  opcode_t              opcode_i,
  input  logic                 carry_i,
  output logic [DataWidth-1:0] result_o,
  output logic                 carry_o,
  output logic                 zero_o,
  output logic                 we_o
);

  logic [DataWidth:0] sum;

  assign sum = {1'b0, acc_i} + {1'b0, imm_i};

  always_comb begin
    result_o = acc_i;
    carry_o  = carry_i;
    we_o     = 1'b1;
    unique case (opcode_i)
      OP_LDI:  result_o = imm_i;
      OP_ADDI: {carry_o, result_o} = sum;
      OP_SUBI: begin
        result_o = acc_i - imm_i;
        carry_o  = (imm_i > acc_i);  // borrow
      end
      OP_ANDI: begin result_o = acc_i & imm_i; carry_o = 1'b0; end
      OP_ORI:  begin result_o = acc_i | imm_i; carry_o = 1'b0; end
      OP_XORI: begin result_o = acc_i ^ imm_i; carry_o = 1'b0; end
      OP_NOT:  begin result_o = ~acc_i;        carry_o = 1'b0; end
      OP_SHL:  begin
        carry_o  = acc_i[DataWidth-1];
        result_o = {acc_i[DataWidth-2:0], 1'b0};
      end
      OP_SHR:  begin
        carry_o  = acc_i[0];
        result_o = {1'b0, acc_i[DataWidth-1:1]};
      end
      default: we_o = 1'b0;  // NOP, jumps, HALT, 0xF
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/jac1_cpu_top.sv
// jac1_cpu_top: JAC1-8 single-cycle 8-bit accumulator processor.
// Fetch, decode, execute and write-back all happen in one clock from a
// fixed 16-word ROM.
// Ports:
//   clk        system clock, rising edge
//   sys_res_n  asynchronous active-low reset
//   reg_val    registered accumulator value
// Build option: define JAC1_HALT_EN to make opcode E a HALT (pc, acc and
// flags freeze until reset) and to place HALT at ROM[14]. Without it,
// opcode E is a NOP and ROM[14] is JMP 0, so the program loops forever.
module jac1_cpu_top
  import jac1_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 sys_res_n,
  output logic [DataWidth-1:0] reg_val
);

  logic [AddrWidth-1:0] pc_q, pc_d;
  logic [DataWidth-1:0] acc_q, acc_d;
  logic                 z_q, z_d;
  logic                 c_q, c_d;

  instr_t               instr;
  logic [DataWidth-1:0] alu_result;
  logic                 alu_carry, alu_zero, alu_we;

  function automatic instr_t rom_read(input logic [AddrWidth-1:0] addr);
    instr_t w;
    unique case (addr)
      4'd0:    w = mk_instr(OP_LDI,  8'hFE);
      4'd1:    w = mk_instr(OP_ADDI, 8'h01);
      4'd2:    w = mk_instr(OP_ADDI, 8'h01);
      4'd3:    w = mk_instr(OP_JZ,   8'h05);
      4'd4:    w = mk_instr(OP_LDI,  8'hAA);
      4'd5:    w = mk_instr(OP_ORI,  8'h30);
      4'd6:    w = mk_instr(OP_SHL,  8'h00);
      4'd7:    w = mk_instr(OP_XORI, 8'hFF);
      4'd8:    w = mk_instr(OP_SUBI, 8'hA0);
      4'd9:    w = mk_instr(OP_JC,   8'h0B);
      4'd10:   w = mk_instr(OP_LDI,  8'h55);
      4'd11:   w = mk_instr(OP_SHR,  8'h00);
      4'd12:   w = mk_instr(OP_ANDI, 8'h0F);
      4'd13:   w = mk_instr(OP_SUBI, 8'h0F);
`ifdef JAC1_HALT_EN
      4'd14:   w = mk_instr(OP_HALT, 8'h00);
`else
      4'd14:   w = mk_instr(OP_JMP,  8'h00);
`endif
      default: w = mk_instr(OP_NOP,  8'h00);
    endcase
    return w;
  endfunction

  assign instr = rom_read(pc_q);

  jac1_alu #(
    .DataWidth(DataWidth)
  ) u_alu (
    .acc_i    (acc_q),
    .imm_i    (instr.imm),
    .opcode_i (instr.opcode),
    .carry_i  (c_q),
    .result_o (alu_result),
    .carry_o  (alu_carry),
    .zero_o   (alu_zero),
    .we_o     (alu_we)
  );

  always_comb begin
    pc_d  = pc_q + 1'b1;  // natural wrap 15 -> 0
    acc_d = acc_q;
    z_d   = z_q;
    c_d   = c_q;
    if (alu_we) begin
      acc_d = alu_result;
      z_d   = alu_zero;
      c_d   = alu_carry;
    end
    unique case (instr.opcode)
      OP_JMP: pc_d = instr.imm[AddrWidth-1:0];
      OP_JZ:  if (z_q)  pc_d = instr.imm[AddrWidth-1:0];
      OP_JC:  if (c_q)  pc_d = instr.imm[AddrWidth-1:0];
      OP_JNZ: if (!z_q) pc_d = instr.imm[AddrWidth-1:0];
`ifdef JAC1_HALT_EN
      OP_HALT: pc_d = pc_q;  // acc/flags already held: ALU does not write
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      pc_q  <= '0;
      acc_q <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      acc_q <= acc_d;
      z_q   <= z_d;
      c_q   <= c_d;
    end
  end

  assign reg_val = acc_q;

endmodule

// File: tb/tb_jac1_cpu_top.sv
module tb_jac1_cpu_top;

  logic       clk = 1'b0;
  logic       sys_res_n;
  logic [7:0] reg_val;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jac1_cpu_top #(
    .DataWidth(8),
    .AddrWidth(4)
  ) dut (
    .clk       (clk),
    .sys_res_n (sys_res_n),
    .reg_val   (reg_val)
  );

  // Behavioural reference: program listing and architectural state as ints.
  int rom_op[16];
  int rom_imm[16];
  int m_pc, m_acc, m_z, m_c;

  // Expected accumulator after edges 1..13 of the default program.
  int exp_seq[13] = '{'hFE, 'hFF, 'h00, 'h00, 'h30, 'h60, 'h9F,
                      'hFF, 'hFF, 'h7F, 'h0F, 'h00, 'h00};

  task automatic load_rom();
    int ops[16]  = '{1, 2, 2, 11, 1, 5, 8, 6, 3, 12, 1, 9, 4, 3, 10, 0};
    int imms[16] = '{'hFE, 1, 1, 5, 'hAA, 'h30, 0, 'hFF, 'hA0, 11, 'h55, 0, 'h0F, 'h0F, 0, 0};
    for (int i = 0; i < 16; i++) begin
      rom_op[i]  = ops[i];
      rom_imm[i] = imms[i];
    end
`ifdef JAC1_HALT_EN
    rom_op[14] = 14;
`endif
  endtask

  function automatic void model_reset();
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0;
  endfunction

  function automatic void model_step();
    int op, imm, nxt, t;
    op  = rom_op[m_pc];
    imm = rom_imm[m_pc];
    nxt = (m_pc + 1) % 16;
    case (op)
      1:  m_acc = imm;
      2:  begin t = m_acc + imm; m_c = (t > 255); m_acc = t % 256; end
      3:  begin m_c = (imm > m_acc); m_acc = (m_acc - imm + 256) % 256; end
      4:  begin m_acc = m_acc & imm; m_c = 0; end
      5:  begin m_acc = m_acc | imm; m_c = 0; end
      6:  begin m_acc = m_acc ^ imm; m_c = 0; end
      7:  begin m_acc = 255 - m_acc; m_c = 0; end
      8:  begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; end
      9:  begin m_c = m_acc % 2; m_acc = m_acc / 2; end
      10: nxt = imm % 16;
      11: if (m_z != 0) nxt = imm % 16;
      12: if (m_c != 0) nxt = imm % 16;
      13: if (m_z == 0) nxt = imm % 16;
`ifdef JAC1_HALT_EN
      14: nxt = m_pc;
`endif
      default: ;
    endcase
    if (op >= 1 && op <= 9) m_z = (m_acc == 0);
    m_pc = nxt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_res_n = 1'b0;
    tick();
    tick();
    sys_res_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    sys_res_n = 1'b0;
    #1;
    total++;
    if (reg_val !== 8'h00) begin
      bad++;
      $display("FAIL reset_async got=%h exp=00", reg_val);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (reg_val !== 8'h00) begin
        bad++;
        $display("FAIL reset_hold edge=%0d got=%h exp=00", i, reg_val);
      end
    end
    sys_res_n = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++;
      if (reg_val !== exp_seq[e-1][7:0]) begin
        bad++;
        $display("FAIL reset_release edge=%0d got=%h exp=%h", e, reg_val, exp_seq[e-1][7:0]);
      end
      $display("reset edge=%0d reg_val=%h", e, reg_val);
    end
  endtask

  task automatic test_branches();
    for (int e = 4; e <= 13; e++) begin
      tick();
      total++;
      if (reg_val !== exp_seq[e-1][7:0]) begin
        bad++;
        $display("FAIL branch edge=%0d got=%h exp=%h", e, reg_val, exp_seq[e-1][7:0]);
      end
      $display("branch edge=%0d reg_val=%h", e, reg_val);
    end
  endtask

`ifdef JAC1_HALT_EN
  task automatic test_halt();
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (reg_val !== 8'h00) begin
        bad++;
        $display("FAIL halt_hold n=%0d got=%h exp=00", i, reg_val);
      end
    end
    $display("halt held 20 edges reg_val=%h", reg_val);
    do_reset();
    tick();
    total++;
    if (reg_val !== 8'hFE) begin
      bad++;
      $display("FAIL halt_restart got=%h exp=fe", reg_val);
    end
    $display("halt restart reg_val=%h", reg_val);
  endtask
`else
  task automatic test_loop();
    for (int e = 14; e <= 40; e++) begin
      tick();
      total++;
      if (reg_val !== exp_seq[(e-1)%13][7:0]) begin
        bad++;
        $display("FAIL loop edge=%0d got=%h exp=%h", e, reg_val, exp_seq[(e-1)%13][7:0]);
      end
      $display("loop edge=%0d reg_val=%h", e, reg_val);
    end
  endtask
`endif

  task automatic test_async_reset();
    do_reset();
    for (int e = 1; e <= 5; e++) tick();
    total++;
    if (reg_val !== 8'h30) begin
      bad++;
      $display("FAIL async_pre got=%h exp=30", reg_val);
    end
    #2 sys_res_n = 1'b0;  // mid-cycle, well before the next edge
    #1;
    total++;
    if (reg_val !== 8'h00) begin
      bad++;
      $display("FAIL async_clear got=%h exp=00", reg_val);
    end
    tick();
    sys_res_n = 1'b1;
    tick();
    total++;
    if (reg_val !== 8'hFE) begin
      bad++;
      $display("FAIL async_restart got=%h exp=fe", reg_val);
    end
    $display("async reset restart reg_val=%h", reg_val);
  endtask

  task automatic test_random();
    int run_len, hold;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      run_len = $urandom_range(1, 45);
      for (int i = 0; i < run_len; i++) begin
        tick();
        model_step();
        total++;
        if (reg_val !== m_acc[7:0]) begin
          bad++;
          $display("FAIL random_run round=%0d step=%0d got=%h exp=%h", r, i, reg_val, m_acc[7:0]);
        end
      end
      $display("random round=%0d steps=%0d reg_val=%h pc_model=%0d", r, run_len, reg_val, m_pc);
      #($urandom_range(1, 3)) sys_res_n = 1'b0;
      #1;
      model_reset();
      total++;
      if (reg_val !== 8'h00) begin
        bad++;
        $display("FAIL random_async round=%0d got=%h exp=00", r, reg_val);
      end
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        tick();
        total++;
        if (reg_val !== 8'h00) begin
          bad++;
          $display("FAIL random_hold round=%0d got=%h exp=00", r, reg_val);
        end
      end
      #($urandom_range(1, 3)) sys_res_n = 1'b1;
    end
  endtask

  initial begin
    load_rom();
    model_reset();
    test_reset();
    test_branches();
`ifdef JAC1_HALT_EN
    test_halt();
`else
    test_loop();
`endif
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jac1_cpu_top.md
Name: jac1_cpu_top

Overview:
- Top level of the JAC1-8 minimal 8-bit accumulator processor.
- Contains a fixed 16-word program ROM, program counter, accumulator, Z/C flags and ALU.
- Executes one instruction per clock: fetch, decode, execute and write-back all complete in a single cycle.
- The only observable output is the accumulator, driven on reg_val.

Parameters:
- DataWidth, 8, accumulator/immediate/ALU width; only 8 is required to work.
- AddrWidth, 4, program counter width (ROM depth 2**AddrWidth = 16).

Ports:
- clk  input  1  system clock, rising-edge active.
- sys_res_n  input  1  reset, asynchronous, active-low.
- reg_val  output  DataWidth  current accumulator value, registered.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset asserted: pc=0, acc=0, Z=0, C=0 immediately, independent of clk; reg_val=0x00.
- After release, the first rising edge executes ROM[0].
- Instruction word is 12 bits: opcode[11:8], imm[7:0].
- Each rising edge: execute ROM[pc]; registers update at that edge; reg_val = acc.
- pc+1 wraps 15->0.
- Opcodes:
  - 0 NOP: no change.
  - 1 LDI: acc=imm; Z updated; C unchanged.
  - 2 ADDI: {C,acc}=acc+imm (9-bit).
  - 3 SUBI: acc=acc-imm mod 256; C=1 iff imm>acc (borrow).
  - 4 ANDI, 5 ORI, 6 XORI: bitwise with imm; C=0.
  - 7 NOT: acc=~acc; C=0.
  - 8 SHL: C=acc[7]; acc={acc[6:0],0}.
  - 9 SHR: C=acc[0]; acc={0,acc[7:1]}.
  - A JMP: pc=imm[3:0].
  - B JZ / C JC / D JNZ: pc=imm[3:0] if condition holds, else pc+1.
  - E HALT: see Optional Feature.
  - F: NOP.
- Z = (new acc==0) for every acc-writing opcode. Jumps and NOP leave acc and flags unchanged.
- imm[7:4] is ignored by jumps.
- Default ROM:
  - 0 LDI FE
  - 1 ADDI 01
  - 2 ADDI 01
  - 3 JZ 5
  - 4 LDI AA
  - 5 ORI 30
  - 6 SHL
  - 7 XORI FF
  - 8 SUBI A0
  - 9 JC 11
  - 10 LDI 55
  - 11 SHR
  - 12 ANDI 0F
  - 13 SUBI 0F
  - 14 JMP 0
  - 15 NOP
- Reset mid-program: state clears asynchronously; execution restarts at ROM[0] on the first edge after release.
- No X on reg_val at any time after reset is first asserted.

Optional Feature:
- Macro JAC1_HALT_EN.
- Defined:
  - Opcode E is HALT: pc, acc and flags freeze until reset.
  - ROM[14] becomes HALT instead of JMP 0.
- Undefined:
  - Opcode E decodes as NOP.
  - ROM[14] is JMP 0, so the program loops forever.

Decomposition:
- Package jac1_pkg holds:
  - opcode localparams (OP_NOP..OP_HALT);
  - instruction width 12;
  - opcode/imm field positions.
- Sub-module jac1_alu is combinational: inputs acc, imm, opcode, C; outputs result, carry_out, zero, write_enable.
- The top holds the ROM case table, pc, acc and flag registers.

Test Plan:
- Reset: hold sys_res_n=0 over edges -> reg_val=0x00; release -> after edges 1..3 reg_val=FE, FF, 00.
- Branches: continue -> edges 4..13 reg_val=00, 30, 60, 9F, FF, FF, 7F, 0F, 00, 00. Values AA and 55 never appear, proving JZ and JC were taken.
- Loop: without JAC1_HALT_EN -> edge 14 reg_val=FE; sequence repeats with period 13 edges.
- Async reset: drop sys_res_n mid-cycle while reg_val=30 -> reg_val=00 before the next edge; release -> next edge FE.
- HALT: with JAC1_HALT_EN -> edge 13 HALT; reg_val stays 00 for 20 further edges; reset then release -> FE again.
